// File: rtl/complex_mult_seq_pkg.sv
// Shared FSM state type for the sequential complex multiplier.
package complex_pkg;

  // Sequencer states: one product per M* state, DONE holds the result.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/complex_mult_seq_if.sv
// Handshake/operand bundle for complex_mult_seq.
interface complex_mult_seq_if #(
  parameter int DW = 8
);
  localparam int OW = 2*DW+1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 conj;
  logic signed [DW-1:0] a_real;
  logic signed [DW-1:0] a_imag;
  logic signed [DW-1:0] b_real;
  logic signed [DW-1:0] b_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] z_real;
  logic signed [OW-1:0] z_imag;

  // Operand source / result sink side.
  modport master (
    output in_valid, conj, a_real, a_imag, b_real, b_imag, out_ready,
    input  in_ready, out_valid, z_real, z_imag
  );

  // Multiplier side.
  modport slave (
    input  in_valid, conj, a_real, a_imag, b_real, b_imag, out_ready,
    output in_ready, out_valid, z_real, z_imag
  );

endinterface

// File: rtl/complex_mult_seq.sv
// Sequential complex multiplier: z = a*b (or a*conj(b)) using one shared
// DW x DW signed multiplier over four cycles, full-precision OW-bit result.
module complex_mult_seq
  import complex_pkg::*;
#(
  parameter  int DW = 8,
  localparam int OW = 2*DW+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 conj,
  input  logic signed [DW-1:0] a_real,
  input  logic signed [DW-1:0] a_imag,
  input  logic signed [DW-1:0] b_real,
  input  logic signed [DW-1:0] b_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] z_real,
  output logic signed [OW-1:0] z_imag
);

  state_t state_q, state_d;
  logic   accept;

  logic signed [DW-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic                 conj_q, conj_d;

  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]   prod_x;

  logic signed [OW-1:0] re_acc_q, re_acc_d, im_acc_q, im_acc_d;
  logic signed [OW-1:0] z_real_q, z_real_d, z_imag_q, z_imag_d;
  logic                 out_valid_q, out_valid_d;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: fixed four-step sequence, DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = M0;
      M0:      state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? M0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State outputs: input handshake and multiplier operand select.
  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    mul_a    = ar_q;
    mul_b    = br_q;
    case (state_q)
      M1:      begin mul_a = ai_q; mul_b = bi_q; end
      M2:      begin mul_a = ai_q; mul_b = br_q; end
      M3:      begin mul_a = ar_q; mul_b = bi_q; end
      default: ;
    endcase
  end

  // The single shared multiplier; product is exact in 2*DW bits, then
  // sign-extended so accumulation can never overflow.
  assign prod   = (2*DW)'(mul_a) * (2*DW)'(mul_b);
  assign prod_x = {prod[2*DW-1], prod};

  // Operand capture and the two accumulators.
  always_comb begin
    ar_d     = ar_q;
    ai_d     = ai_q;
    br_d     = br_q;
    bi_d     = bi_q;
    conj_d   = conj_q;
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
    if (accept) begin
      ar_d   = a_real;
      ai_d   = a_imag;
      br_d   = b_real;
      bi_d   = b_imag;
      conj_d = conj;
    end
    // conj(b) flips the sign of bi, i.e. of the ai*bi and ar*bi terms.
    case (state_q)
      M0:      re_acc_d = prod_x;
      M1:      re_acc_d = conj_q ? (re_acc_q + prod_x) : (re_acc_q - prod_x);
      M2:      im_acc_d = prod_x;
      M3:      im_acc_d = conj_q ? (im_acc_q - prod_x) : (im_acc_q + prod_x);
      default: ;
    endcase
  end

  // Result register: loaded leaving M3, held until consumed, retained after.
  always_comb begin
    z_real_d    = z_real_q;
    z_imag_d    = z_imag_q;
    out_valid_d = out_valid_q;
    if (state_q == M3) begin
      z_real_d    = re_acc_q;
      z_imag_d    = im_acc_d;
      out_valid_d = 1'b1;
    end else if ((state_q == DONE) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath and result flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      conj_q      <= 1'b0;
      re_acc_q    <= '0;
      im_acc_q    <= '0;
      z_real_q    <= '0;
      z_imag_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      br_q        <= br_d;
      bi_q        <= bi_d;
      conj_q      <= conj_d;
      re_acc_q    <= re_acc_d;
      im_acc_q    <= im_acc_d;
      z_real_q    <= z_real_d;
      z_imag_q    <= z_imag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z_real    = z_real_q;
  assign z_imag    = z_imag_q;

endmodule

// File: tb/tb_complex_mult_seq.sv
// Self-checking bench for complex_mult_seq: directed cases plus a random
// back-to-back stream scored against a plain complex-arithmetic model.
module tb_complex_mult_seq;
  localparam int DW = 8;
  localparam int OW = 2*DW+1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  complex_mult_seq_if #(.DW(DW)) bus ();

  complex_mult_seq #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .conj     (bus.conj),
    .a_real   (bus.a_real),
    .a_imag   (bus.a_imag),
    .b_real   (bus.b_real),
    .b_imag   (bus.b_imag),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .z_real   (bus.z_real),
    .z_imag   (bus.z_imag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
  } cplx_t;

  cplx_t exp_q[$];
  cplx_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_res   = 0;
  logic  prev_stall = 1'b0;
  logic signed [OW-1:0] prev_zr = '0;
  logic signed [OW-1:0] prev_zi = '0;

  // Reference: a * b, or a * conj(b), in plain integer arithmetic.
  function automatic cplx_t ref_mult(input int ar, input int ai, input int br,
                                     input int bi, input bit cj);
    cplx_t r;
    int    bim;
    bim  = cj ? -bi : bi;
    r.re = ar*br - ai*bim;
    r.im = ar*bim + ai*br;
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: inputs only change just after a rising edge, so values seen
  // on the falling edge are the ones the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_z_real", bus.z_real, prev_zr);
        chk("stall_z_imag", bus.z_imag, prev_zi);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_res++;
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("z_real", bus.z_real, mon_e.re);
          chk("z_imag", bus.z_imag, mon_e.im);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_mult(int'(bus.a_real), int'(bus.a_imag),
                                 int'(bus.b_real), int'(bus.b_imag), bus.conj));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_zr    = bus.z_real;
      prev_zi    = bus.z_imag;
    end
  end

  // Offer one operand set, wait for acceptance, then count cycles until
  // out_valid (cycle 1 is the one right after the accepting edge).
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit cj, input bit rdy, output int lat);
    int n;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a_real    = DW'(ar);
    bus.a_imag    = DW'(ai);
    bus.b_real    = DW'(br);
    bus.b_imag    = DW'(bi);
    bus.conj      = cj;
    bus.out_ready = rdy;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    int acc_cnt;
    int cyc;
    bit acc;

    bus.in_valid  = 1'b0;
    bus.conj      = 1'b0;
    bus.a_real    = '0;
    bus.a_imag    = '0;
    bus.b_real    = '0;
    bus.b_imag    = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z_real", bus.z_real, 0);
    chk("rst_z_imag", bus.z_imag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // (3+4j)(5-2j) = 23+14j
    send(3, 4, 5, -2, 1'b0, 1'b1, lat);
    chk("basic_latency", lat, 5);
    chk("basic_z_real", bus.z_real, 23);
    chk("basic_z_imag", bus.z_imag, 14);

    // (3+4j)(5+2j) = 7+26j
    send(3, 4, 5, -2, 1'b1, 1'b1, lat);
    chk("conj_latency", lat, 5);
    chk("conj_z_real", bus.z_real, 7);
    chk("conj_z_imag", bus.z_imag, 26);

    // Most negative operands: 0 + 32768j needs the full 17 bits.
    send(-128, -128, -128, -128, 1'b0, 1'b1, lat);
    chk("min_latency", lat, 5);
    chk("min_z_real", bus.z_real, 0);
    chk("min_z_imag", bus.z_imag, 32768);

    // Back-pressure: (10-7j)(-3+12j) = 54+141j held for 10 stalled cycles.
    send(10, -7, -3, 12, 1'b0, 1'b0, lat);
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_z_real", bus.z_real, 54);
      chk("bp_z_imag", bus.z_imag, 141);
    end
    // Release with new operands on the same edge: (-50+60j)(7+9j) = -890-30j
    send(-50, 60, 7, -9, 1'b1, 1'b1, lat);
    chk("b2b_latency", lat, 5);
    chk("b2b_z_real", bus.z_real, -890);
    chk("b2b_z_imag", bus.z_imag, -30);

    // Reset pulse in the middle of an operation.
    @(posedge clk); #1;
    bus.a_real   = DW'(20);
    bus.a_imag   = DW'(21);
    bus.b_real   = DW'(-22);
    bus.b_imag   = DW'(23);
    bus.conj     = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_z_real", bus.z_real, 0);
    chk("midrst_z_imag", bus.z_imag, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("postrst_no_result", seen, 0);
    chk("postrst_z_real", bus.z_real, 0);

    // Operands waiting at reset release are taken on the first edge:
    // (7-8j)(9+10j) = 143-2j
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.a_real   = DW'(7);
    bus.a_imag   = DW'(-8);
    bus.b_real   = DW'(9);
    bus.b_imag   = DW'(10);
    bus.conj     = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk("rel_latency", lat, 5);
    chk("rel_z_real", bus.z_real, 143);
    chk("rel_z_imag", bus.z_imag, -2);

    // Random back-to-back stream with random consumer stalls.
    acc_cnt = 0;
    cyc     = 0;
    @(posedge clk); #1;
    n_res         = 0;
    bus.in_valid  = 1'b1;
    bus.a_real    = DW'($urandom);
    bus.a_imag    = DW'($urandom);
    bus.b_real    = DW'($urandom);
    bus.b_imag    = DW'($urandom);
    bus.conj      = 1'($urandom);
    bus.out_ready = ($urandom_range(0, 9) < 7);
    while (acc_cnt < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cnt++;
        bus.in_valid = ($urandom_range(0, 9) != 0);
        bus.a_real   = DW'($urandom);
        bus.a_imag   = DW'($urandom);
        bus.b_real   = DW'($urandom);
        bus.b_imag   = DW'($urandom);
        bus.conj     = 1'($urandom);
      end else if (!bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("stream_accepted", acc_cnt, 1000);
    chk("stream_results", n_res, 1000);
    chk("stream_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
